fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queued entries (power of two, 2..16).
REQ-002 SHALL have parameter DROP_AFTER_EXC, default 1, discard non-redirect entries that follow an accepted exception entry.
REQ-003 SHALL have port clk_i, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port flush_i, input, 1, discard all entries and drop state.
REQ-006 SHALL have port in_valid_i, input, 1, fetched entry offered.
REQ-007 SHALL have port in_ready_o, output, 1, queue accepts an entry.
REQ-008 SHALL have port in_instr_i, input, fetched_instr_t, pc, if_reason, instr_word, exception.
REQ-009 SHALL have port out_valid_o, output, 1, head entry valid toward decode.
REQ-010 SHALL have port out_ready_i, input, 1, decode consumes head.
REQ-011 SHALL have port out_instr_o, output, fetched_instr_t, head entry.
REQ-012 SHALL have port count_o, output, $clog2(DEPTH)+1, number of stored entries.

Function
REQ-013 SHALL be a circular buffer of DEPTH entries with read and write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-014 SHALL drive in_ready_o = (count_o < DEPTH) and SHALL NOT make it depend on in_valid_i or out_ready_i.
REQ-015 SHALL drive out_valid_o = (count_o != 0) and out_instr_o from the read-pointer entry, both from registers only.
REQ-016 SHALL accept an entry when in_valid_i & in_ready_o, and SHALL present it no earlier than the next cycle (latency 1, no bypass).
REQ-017 SHALL remove the head when out_valid_o & out_ready_i.
REQ-018 SHALL treat an accepted entry with in_instr_i.if_reason[0]=1 (misprediction, prot/satp change, exception, flush) as a redirect: after the edge the queue holds only that entry, count_o=1.
REQ-019 SHALL complete a dequeue in the same cycle as an accepted redirect; the dequeued entry is consumed, all other older entries are discarded.
REQ-020 SHALL support simultaneous enqueue and dequeue when full? No: when full, in_ready_o=0 and only dequeue occurs.
REQ-021 SHALL, with simultaneous non-redirect enqueue and dequeue at count N (0<N<DEPTH), keep count_o at N.
REQ-022 SHALL, when DROP_AFTER_EXC=1 and an accepted entry has exception.valid=1, set a drop flag; while set, accepted entries with if_reason[0]=0 are consumed (in_ready_o unaffected) but not stored.
REQ-023 SHALL clear the drop flag on an accepted redirect entry; if that redirect itself has exception.valid=1 the flag is set again.
REQ-024 SHALL, when DROP_AFTER_EXC=0, never set the drop flag.
REQ-025 SHALL, on flush_i=1, set count_o=0, clear pointers and drop flag at the edge, ignoring any concurrent enqueue; a concurrent dequeue handshake is still considered completed by the consumer.
REQ-026 SHALL give flush_i priority over redirect, enqueue and dequeue.

Reset
REQ-027 SHALL, while rst_i=1 at a rising edge, set read/write pointers to 0, count_o=0, drop flag=0; thus out_valid_o=0, in_ready_o=1 the next cycle.
REQ-028 SHALL apply reset mid-operation identically, discarding all stored entries and any concurrent handshake.
REQ-029 SHALL leave storage array contents unreset; out_instr_o is don't-care while out_valid_o=0.

Verification
REQ-030 SHALL cover fill/drain: DEPTH=4, enqueue pc 0x100,0x104,0x108,0x10C with out_ready_i=0 -> count_o=4, in_ready_o=0; then out_ready_i=1 -> pcs emerge in order, one per cycle, count_o reaches 0.
REQ-031 SHALL cover wrap-around: 10 streaming entries with in/out handshakes every cycle -> count_o constant 1 after first cycle, order preserved across pointer wrap.
REQ-032 SHALL cover redirect: 3 entries queued, enqueue pc 0x2000 if_reason=IF_MISPREDICT with dequeue of head -> head consumed, next cycle count_o=1, out_instr_o.pc=0x2000.
REQ-033 SHALL cover exception drop: DROP_AFTER_EXC=1, enqueue pc 0x300 exception.valid=1 then pcs 0x304,0x308 IF_PREFETCH -> count_o=1; then enqueue 0x400 IF_EXCEPTION -> count_o=1, head 0x400 after draining 0x300... (count_o=1 holds 0x400 only).
REQ-034 SHALL cover flush vs enqueue: count_o=2, flush_i=1 with in_valid_i=1 pc 0x500 -> next cycle count_o=0, out_valid_o=0.
REQ-035 SHALL cover reset mid-operation: count_o=3, rst_i=1 for one edge -> count_o=0, in_ready_o=1, out_valid_o=0; subsequent enqueue of pc 0x600 appears at head one cycle later.

Source files
------------

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch-to-decode circular queue with redirect collapse and post-exception drop
package fetch_queue_pkg;

    localparam logic [3:0] IF_PREFETCH    = 4'b0000;
    localparam logic [3:0] IF_MISPREDICT  = 4'b0001;
    localparam logic [3:0] IF_PROT_CHANGE = 4'b0011;
    localparam logic [3:0] IF_EXCEPTION   = 4'b0101;
    localparam logic [3:0] IF_FLUSH       = 4'b0111;

    typedef struct packed {
        logic        valid;
        logic [31:0] cause;
        logic [31:0] tval;
    } exception_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  if_reason;
        logic [31:0] instr_word;
        exception_t  exception;
    } fetched_instr_t;

endpackage

module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH          = 4,
    parameter bit          DROP_AFTER_EXC = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  fetched_instr_t             in_instr_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output fetched_instr_t             out_instr_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           drop_q, drop_d;
    fetched_instr_t mem_q [DEPTH];
    fetched_instr_t mem_d [DEPTH];

    logic push;
    logic pop;
    logic is_redirect;
    logic store;

    assign in_ready_o  = (count_q < CW'(DEPTH));
    assign out_valid_o = (count_q != '0);
    assign out_instr_o = mem_q[rd_ptr_q];
    assign count_o     = count_q;

    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;
    assign is_redirect = in_instr_i.if_reason[0];
    // While dropping, only a redirect is allowed to land in storage.
    assign store       = push & (is_redirect | ~drop_q);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        mem_d    = mem_q;

        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            drop_d   = 1'b0;
        end else if (push && is_redirect) begin
            // Collapse the queue onto the redirect entry; any concurrent pop is implicitly honoured.
            mem_d[wr_ptr_q] = in_instr_i;
            rd_ptr_d        = wr_ptr_q;
            wr_ptr_d        = wr_ptr_q + PW'(1);
            count_d         = CW'(1);
            drop_d          = DROP_AFTER_EXC & in_instr_i.exception.valid;
        end else begin
            if (store) begin
                mem_d[wr_ptr_q] = in_instr_i;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({store, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (push && DROP_AFTER_EXC && in_instr_i.exception.valid) begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // Payload storage carries no reset; out_instr_o is only meaningful with out_valid_o.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed and randomized checks of fetch_queue against a queue-based model
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam bit          DAE   = 1'b1;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    fetched_instr_t in_instr;
    logic           out_valid;
    logic           out_ready;
    fetched_instr_t out_instr;
    logic [2:0]     count;

    int checks = 0;
    int errors = 0;

    fetched_instr_t mq[$];
    bit             mdrop;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .DROP_AFTER_EXC(DAE)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_instr_i  (in_instr),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_instr_o (out_instr),
        .count_o     (count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic fetched_instr_t mk(input logic [31:0] pc, input logic [3:0] rsn, input bit exc);
        fetched_instr_t f;
        f.pc               = pc;
        f.if_reason        = rsn;
        f.instr_word       = pc ^ 32'h5a5a_0013;
        f.exception.valid  = exc;
        f.exception.cause  = exc ? 32'd2 : 32'd0;
        f.exception.tval   = exc ? pc : 32'd0;
        return f;
    endfunction

    task automatic compare_model();
        check("count", 64'(count), 64'(mq.size()));
        check("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
        check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            check("head_pc", 64'(out_instr.pc), 64'(mq[0].pc));
            check("head_word", 64'(out_instr.instr_word), 64'(mq[0].instr_word));
            check("head_meta", 64'({out_instr.if_reason, out_instr.exception.valid}),
                  64'({mq[0].if_reason, mq[0].exception.valid}));
        end
    endtask

    // Reference behaviour: pop first, then either collapse on redirect or append unless dropping.
    task automatic model_update();
        bit acc, deq;
        if (rst || flush) begin
            mq.delete();
            mdrop = 1'b0;
        end else begin
            acc = in_valid && (mq.size() < DEPTH);
            deq = out_ready && (mq.size() != 0);
            if (deq) void'(mq.pop_front());
            if (acc) begin
                if (in_instr.if_reason[0]) begin
                    mq.delete();
                    mq.push_back(in_instr);
                    mdrop = DAE && in_instr.exception.valid;
                end else begin
                    if (!mdrop) mq.push_back(in_instr);
                    if (DAE && in_instr.exception.valid) mdrop = 1'b1;
                end
            end
        end
    endtask

    task automatic cycle(input bit v, input bit r, input bit fl, input bit rs, input fetched_instr_t ins);
        in_valid  = v;
        out_ready = r;
        flush     = fl;
        rst       = rs;
        in_instr  = ins;
        compare_model();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle(input bit r);
        cycle(1'b0, r, 1'b0, 1'b0, mk(32'h0, IF_PREFETCH, 1'b0));
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_instr  = mk(32'h0, IF_PREFETCH, 1'b0);
        mq.delete();
        mdrop = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check("rst_count", 64'(count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);

        // fill then drain
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, mk(32'h100 + 32'(4 * i), IF_PREFETCH, 1'b0));
        check("full_count", 64'(count), 64'd4);
        check("full_in_ready", 64'(in_ready), 64'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, mk(32'h1FC, IF_PREFETCH, 1'b0));
        for (int i = 0; i < 4; i++) begin
            check("drain_pc", 64'(out_instr.pc), 64'(32'h100 + 32'(4 * i)));
            idle(1'b1);
        end
        check("drained_count", 64'(count), 64'd0);

        // streaming across pointer wrap
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0, mk(32'h1000 + 32'(4 * i), IF_PREFETCH, 1'b0));
            check("stream_count", 64'(count), 64'd1);
            check("stream_pc", 64'(out_instr.pc), 64'(32'h1000 + 32'(4 * i)));
        end
        drain();

        // redirect collapses queue while head is consumed
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, mk(32'h1800 + 32'(4 * i), IF_PREFETCH, 1'b0));
        cycle(1'b1, 1'b1, 1'b0, 1'b0, mk(32'h2000, IF_MISPREDICT, 1'b0));
        check("redir_count", 64'(count), 64'd1);
        check("redir_pc", 64'(out_instr.pc), 64'h2000);
        drain();

        // exception drop window, closed by a redirect
        cycle(1'b1, 1'b0, 1'b0, 1'b0, mk(32'h300, IF_PREFETCH, 1'b1));
        cycle(1'b1, 1'b0, 1'b0, 1'b0, mk(32'h304, IF_PREFETCH, 1'b0));
        cycle(1'b1, 1'b0, 1'b0, 1'b0, mk(32'h308, IF_PREFETCH, 1'b0));
        check("drop_count", 64'(count), 64'd1);
        check("drop_head", 64'(out_instr.pc), 64'h300);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, mk(32'h400, IF_EXCEPTION, 1'b0));
        check("exc_redir_count", 64'(count), 64'd1);
        check("exc_redir_pc", 64'(out_instr.pc), 64'h400);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, mk(32'h404, IF_PREFETCH, 1'b0));
        check("drop_cleared", 64'(count), 64'd2);
        drain();

        // flush beats a concurrent enqueue
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, mk(32'h480 + 32'(4 * i), IF_PREFETCH, 1'b0));
        cycle(1'b1, 1'b1, 1'b1, 1'b0, mk(32'h500, IF_PREFETCH, 1'b0));
        check("flush_count", 64'(count), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);

        // reset mid-operation
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, mk(32'h580 + 32'(4 * i), IF_PREFETCH, 1'b0));
        cycle(1'b1, 1'b1, 1'b0, 1'b1, mk(32'h5F0, IF_PREFETCH, 1'b0));
        check("mid_rst_count", 64'(count), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, mk(32'h600, IF_PREFETCH, 1'b0));
        check("post_rst_pc", 64'(out_instr.pc), 64'h600);
        check("post_rst_valid", 64'(out_valid), 64'd1);
        drain();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] rsn;
            int         sel;
            sel = int'($urandom_range(0, 15));
            case (sel)
                10:      rsn = IF_MISPREDICT;
                11:      rsn = IF_PROT_CHANGE;
                12:      rsn = IF_EXCEPTION;
                13:      rsn = IF_FLUSH;
                default: rsn = IF_PREFETCH;
            endcase
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 63) == 0), ($urandom_range(0, 127) == 0),
                  mk($urandom, rsn, ($urandom_range(0, 9) == 0)));
        end
        compare_model();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
